packet_serializer: RTL

- Downstream consumer of the info-frame and other packet generators.
- Takes one fully formed HDMI data-island packet: a 24-bit header plus four 56-bit subpackets.
- Appends the BCH ECC parity to the header and to each subpacket.
- Serializes the packet over 32 pixel clocks as 9 bits per clock, ready for the TERC4 encoders on channels 0 (bit 2), 1 and 2.

---
 rtl/hdmi_packet_pkg.sv | 16 +
 rtl/bch_ecc_step.sv | 20 ++
 rtl/packet_serializer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared constants and types for the HDMI data-island packet serializer.
package hdmi_packet_pkg;

  localparam logic [7:0] ECC_POLY    = 8'h83;
  localparam int         HEADER_BITS = 24;
  localparam int         SUB_BITS    = 56;
  localparam int         BEATS       = 32;

  typedef logic [SUB_BITS-1:0] subpacket_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

endpackage

// File: rtl/bch_ecc_step.sv
// One serial step of the data-island BCH parity register, absorbing BITS data bits
// (bit 0 first) using the x^8+x^7+x^6+1 feedback.
module bch_ecc_step
  import hdmi_packet_pkg::*;
#(
  parameter int BITS = 1
) (
  input  logic [7:0]      parity_in,
  input  logic [BITS-1:0] data,
  output logic [7:0]      parity_out
);

  always_comb begin
    parity_out = parity_in;
    for (int i = 0; i < BITS; i++) begin
      parity_out = (parity_out >> 1) ^ ((data[i] ^ parity_out[0]) ? ECC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/packet_serializer.sv
// Serializes one HDMI data-island packet (header + 4 subpackets + BCH parity) over 32 beats.
// Optional InfoFrame checksum monitor: define HDMI_PACKET_CHECKSUM_CHECK_EN.
module packet_serializer
  import hdmi_packet_pkg::*;
#(
  parameter int BACK_TO_BACK = 1
) (
  input  logic                   clk_pixel,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [23:0]            header,
  input  subpacket_t [3:0]       sub,
  output logic [8:0]             packet_data,
  output logic                   packet_active,
  output logic                   packet_first,
  output logic                   packet_last,
  output logic                   checksum_error
);

  ser_state_t       state;
  logic [4:0]       counter;
  logic [23:0]      header_q;
  subpacket_t [3:0] sub_q;
  logic [7:0]       hdr_parity;
  logic [7:0]       hdr_seed;
  logic [7:0]       hdr_next;
  logic [7:0]       sub_parity [4];
  logic [7:0]       sub_seed [4];
  logic [7:0]       sub_next [4];
  logic [5:0]       bit_idx;
  logic             accept;

  assign bit_idx  = {counter, 1'b0};
  assign in_ready = (state == IDLE) || ((BACK_TO_BACK != 0) && (counter == 5'd31));
  assign accept   = in_valid && in_ready;

  // Parity registers restart from zero on beat 0, so a back-to-back packet needs no clear cycle.
  assign hdr_seed = (counter == 5'd0) ? 8'h00 : hdr_parity;

  bch_ecc_step #(.BITS(1)) u_hdr_ecc (
    .parity_in  (hdr_seed),
    .data       (header_q[counter]),
    .parity_out (hdr_next)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sub_ecc
    assign sub_seed[g] = (counter == 5'd0) ? 8'h00 : sub_parity[g];

    bch_ecc_step #(.BITS(2)) u_sub_ecc (
      .parity_in  (sub_seed[g]),
      .data       (sub_q[g][bit_idx +: 2]),
      .parity_out (sub_next[g])
    );
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state      <= IDLE;
      counter    <= '0;
      hdr_parity <= '0;
      for (int i = 0; i < 4; i++) begin
        sub_parity[i] <= '0;
      end
    end else begin
      if (accept) begin
        header_q <= header;
        sub_q    <= sub;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SEND;
            counter <= '0;
          end
        end
        SEND: begin
          counter <= counter + 5'd1;
          if (counter < 5'd24) begin
            hdr_parity <= hdr_next;
          end
          if (counter < 5'd28) begin
            for (int i = 0; i < 4; i++) begin
              sub_parity[i] <= sub_next[i];
            end
          end
          if ((counter == 5'd31) && !accept) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign packet_active = (state == SEND);
  assign packet_first  = packet_active && (counter == 5'd0);
  assign packet_last   = packet_active && (counter == 5'd31);

  // Parity beats reuse the low counter bits as the parity bit index (24..31 and 28..31).
  always_comb begin
    packet_data = '0;
    if (state == SEND) begin
      packet_data[0] = (counter < 5'd24) ? header_q[counter] : hdr_parity[counter[2:0]];
      for (int i = 0; i < 4; i++) begin
        if (counter < 5'd28) begin
          packet_data[1+i] = sub_q[i][bit_idx];
          packet_data[5+i] = sub_q[i][bit_idx + 6'd1];
        end else begin
          packet_data[1+i] = sub_parity[i][{counter[1:0], 1'b0}];
          packet_data[5+i] = sub_parity[i][{counter[1:0], 1'b1}];
        end
      end
    end
  end

`ifdef HDMI_PACKET_CHECKSUM_CHECK_EN
  logic [7:0] csum;

  always_comb begin
    csum = header[7:0] + header[15:8] + header[23:16];
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 7; b++) begin
        csum = csum + sub[i][8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      checksum_error <= 1'b0;
    end else if (accept && header[7] && (csum != 8'h00)) begin
      checksum_error <= 1'b1;
    end
  end
`else
  assign checksum_error = 1'b0;
`endif

endmodule
